exc_pipe_ctrl: RTL and testbench
================================

Name: exc_pipe_ctrl

Overview:
- Exception/interrupt sequencer for the 5-stage MIPS pipeline.
- Carries per-instruction exception info (code, PC, branch-delay flag) from F through D and E to M.
- Presents the oldest exception to CP0 at M and drives pipeline flush plus next-PC redirect to the handler or EPC.
- Sits between the hazard unit, the stage datapaths and CP0.

Parameters:
HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC
RESET_PC, 32'h0000_3000, PC loaded into bubble stage regs at reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard stall: F/D hold, bubble into E
f_pc  in  32  PC of instruction in F
f_adel  in  1  fetch address error (misaligned or out of range)
f_bd  in  1  F instruction is in a delay slot (D holds a branch/jump)
d_ri  in  1  D instruction is reserved/unknown
e_ov  in  1  E arithmetic overflow (add/addi/sub)
e_adel  in  1  E load address error (computed in E, reported with the instruction)
e_ades  in  1  E store address error
m_is_eret  in  1  M holds eret
cp0_take  in  1  CP0 is accepting an exception or interrupt this cycle
cp0_epc  in  32  EPC from CP0
cp0_pc  out  32  macro PC of the M instruction
cp0_bd  out  1  M instruction is in a delay slot
cp0_exc_code  out  5  exception code of the M instruction
cp0_exl_set  out  1  M instruction carries an exception
cp0_exl_clr  out  1  eret retiring
flush  out  1  clear D/E/M; F restarts at npc
redir  out  1  PC mux select for npc
npc  out  32  redirect target
m_kill  out  1  suppress M memory write and W register write
in_handler  out  1  state == HANDLER

Behaviour:
- Stage records D, E, M each hold {pc[31:0], bd, exc, code[4:0]}.
- Reset: every record = {RESET_PC, 0, 0, 0}; FSM = NORMAL. All outputs derive from cleared records and are 0, except cp0_pc = RESET_PC.
- Code merge per stage, earliest detection wins (a record's exc is never overwritten):
  - D takes f_adel → AdEL(4).
  - E takes the D record, else d_ri → RI(10).
  - M takes the E record, else e_adel → AdEL(4), e_ades → AdES(5), e_ov → Ov(12). Priority within E: adel > ades > ov.
- Normal advance: D←F, E←D, M←E at each posedge.
- stall=1: D holds. E loads a bubble that inherits the D record's pc and bd with exc=0. M←E as usual. Bubbles therefore always carry a valid macro PC for interrupt EPC.
- Outputs from M:
  - cp0_pc = M.pc
  - cp0_bd = M.bd
  - cp0_exc_code = M.code
  - cp0_exl_set = M.exc & ~reset
- cp0_take=1:
  - Combinationally assert flush=1, redir=1, npc=HANDLER_ADDR, m_kill=1.
  - At the next edge D/E/M load bubble records {HANDLER_ADDR, 0, 0, 0}.
  - FSM NORMAL→HANDLER. If already HANDLER, stay HANDLER.
- m_is_eret=1 with cp0_take=0:
  - Assert cp0_exl_clr=1, flush=1, redir=1, npc=cp0_epc, m_kill=0 (eret has no side effects).
  - Bubbles at the next edge carry pc=cp0_epc. FSM HANDLER→NORMAL.
  - eret in NORMAL behaves identically; FSM stays NORMAL.
- Simultaneous cp0_take and m_is_eret: take wins. exl_clr=0; redirect to HANDLER_ADDR.
- flush overrides stall: the stage records reload even when stall=1.
- An exception in M with cp0_take=0 (EXL already set) is not re-raised. The instruction proceeds normally (m_kill=0).
- Reset mid-operation: records and FSM clear on that edge; flush/redir are not asserted.

Decomposition:
- Package exc_pkg:
  - EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12
  - stage-record struct/width constants
  - FSM state encoding (NORMAL=0, HANDLER=1)
- Sub-module exc_stage_reg: one record register with load/hold/bubble/flush controls and merge-in code. Instantiated three times.

Test Plan:
1. Overflow: addi overflow at f_pc=0x3010, no stall → three cycles later cp0_exc_code=12, cp0_pc=0x3010, cp0_exl_set=1. With cp0_take=1: npc=0x4180, flush=1, m_kill=1, in_handler=1 next cycle.
2. Delay-slot RI: branch at 0x3020, RI slot at 0x3024 (f_bd=1) → at M: cp0_bd=1, cp0_pc=0x3024, code=10.
3. Stall-bubble interrupt: stall held 2 cycles behind 0x3040, cp0_take asserted while M holds the bubble → cp0_pc=0x3040, cp0_exl_set=0, redirect to 0x4180.
4. Priority: f_adel on 0x3001 plus d_ri on the same instruction → code=4 at M, not 10.
5. eret: in HANDLER, m_is_eret=1, cp0_epc=0x3044 → exl_clr=1, npc=0x3044, FSM NORMAL. The same cycle with cp0_take=1 → exl_clr=0, npc=0x4180.
6. Reset during HANDLER with a pending exception in E → next cycle all exl_set/flush=0, cp0_pc=0x3000, in_handler=0.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception pipeline controller.
package exc_pkg;

    // CP0 Cause.ExcCode values produced by this pipeline.
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Per-instruction exception record carried alongside each stage.
    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
        logic        exc;
        logic [4:0]  code;
    } stageRec_t;

    localparam int STAGE_REC_W = $bits(stageRec_t);

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } excState_t;

    // Record with no exception attached; used for bubbles and fresh fetches.
    function automatic stageRec_t makeBubble(input logic [31:0] pc, input logic bd);
        stageRec_t rec;
        rec.pc   = pc;
        rec.bd   = bd;
        rec.exc  = 1'b0;
        rec.code = EXC_INT;
        return rec;
    endfunction

    // The earliest exception wins: a new one is attached only to a clean record.
    function automatic stageRec_t mergeRec(input stageRec_t rec, input logic newExc,
                                           input logic [4:0] newCode);
        stageRec_t res;
        res = rec;
        if (!rec.exc && newExc) begin
            res.exc  = 1'b1;
            res.code = newCode;
        end
        return res;
    endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// One pipeline stage's exception record: reset > flush > bubble > load > hold.
module exc_stage_reg
    import exc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic        flush,
    input  logic [31:0] flushPc,
    input  stageRec_t   inRec,
    input  logic        mergeExc,
    input  logic [4:0]  mergeCode,
    output stageRec_t   outRec
);

    // Record update; a bubble keeps the upstream macro PC so interrupts get a valid EPC.
    // NOTE: non-blocking (<=) so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            outRec <= makeBubble(RESET_PC, 1'b0);
        end else if (flush) begin
            outRec <= makeBubble(flushPc, 1'b0);
        end else if (bubble) begin
            outRec <= makeBubble(inRec.pc, inRec.bd);
        end else if (load) begin
            outRec <= mergeRec(inRec, mergeExc, mergeCode);
        end
    end

endmodule

// File: rtl/exc_pipe_ctrl.sv
// Exception/interrupt sequencer: carries exception records F->D->E->M,
// presents the M record to CP0 and drives flush plus PC redirect.
module exc_pipe_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] RESET_PC     = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] f_pc,
    input  logic        f_adel,
    input  logic        f_bd,
    input  logic        d_ri,
    input  logic        e_ov,
    input  logic        e_adel,
    input  logic        e_ades,
    input  logic        m_is_eret,
    input  logic        cp0_take,
    input  logic [31:0] cp0_epc,
    output logic [31:0] cp0_pc,
    output logic        cp0_bd,
    output logic [4:0]  cp0_exc_code,
    output logic        cp0_exl_set,
    output logic        cp0_exl_clr,
    output logic        flush,
    output logic        redir,
    output logic [31:0] npc,
    output logic        m_kill,
    output logic        in_handler
);

    stageRec_t dRec, eRec, mRec;
    excState_t state, nextState;
    logic      eExc;
    logic [4:0] eCode;

    // E-stage exception code, priority adel > ades > ov.
    // NOTE: defaults first so every path assigns eCode and no latch is inferred.
    always_comb begin
        eCode = EXC_OV;
        if (e_adel) begin
            eCode = EXC_ADEL;
        end else if (e_ades) begin
            eCode = EXC_ADES;
        end
    end

    assign eExc = e_adel | e_ades | e_ov;

    // D: holds on stall, otherwise takes the fetched instruction.
    exc_stage_reg #(.RESET_PC(RESET_PC)) uDStage (
        .clk(clk), .reset(reset), .load(~stall), .bubble(1'b0), .flush(flush),
        .flushPc(npc), .inRec(makeBubble(f_pc, f_bd)), .mergeExc(f_adel),
        .mergeCode(EXC_ADEL), .outRec(dRec)
    );

    // E: takes a bubble (inheriting D's pc/bd) while D is stalled.
    exc_stage_reg #(.RESET_PC(RESET_PC)) uEStage (
        .clk(clk), .reset(reset), .load(1'b1), .bubble(stall), .flush(flush),
        .flushPc(npc), .inRec(dRec), .mergeExc(d_ri),
        .mergeCode(EXC_RI), .outRec(eRec)
    );

    // M: always advances from E.
    exc_stage_reg #(.RESET_PC(RESET_PC)) uMStage (
        .clk(clk), .reset(reset), .load(1'b1), .bubble(1'b0), .flush(flush),
        .flushPc(npc), .inRec(eRec), .mergeExc(eExc),
        .mergeCode(eCode), .outRec(mRec)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= nextState;
        end
    end

    // Next state and redirect control; a CP0 take beats a simultaneous eret.
    always_comb begin
        nextState   = state;
        flush       = 1'b0;
        redir       = 1'b0;
        npc         = 32'h0;
        m_kill      = 1'b0;
        cp0_exl_clr = 1'b0;
        if (!reset) begin
            if (cp0_take) begin
                nextState = HANDLER;
                flush     = 1'b1;
                redir     = 1'b1;
                npc       = HANDLER_ADDR;
                m_kill    = 1'b1;
            end else if (m_is_eret) begin
                nextState   = NORMAL;
                flush       = 1'b1;
                redir       = 1'b1;
                npc         = cp0_epc;
                cp0_exl_clr = 1'b1;
            end
        end
    end

    assign cp0_pc       = mRec.pc;
    assign cp0_bd       = mRec.bd;
    assign cp0_exc_code = mRec.code;
    assign cp0_exl_set  = mRec.exc & ~reset;
    assign in_handler   = (state == HANDLER);

endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// Directed bench for exc_pipe_ctrl with an M-stage scoreboard.
module tb_exc_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, f_adel, f_bd, d_ri, e_ov, e_adel, e_ades;
    logic        m_is_eret, cp0_take;
    logic [31:0] f_pc, cp0_epc;
    logic [31:0] cp0_pc, npc;
    logic        cp0_bd, cp0_exl_set, cp0_exl_clr, flush, redir, m_kill, in_handler;
    logic [4:0]  cp0_exc_code;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        string       tag;
        logic [31:0] pc;
        logic        bd;
        logic        exc;
        logic [4:0]  code;
    } expItem_t;

    expItem_t sbq[$];

    exc_pipe_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .f_pc(f_pc), .f_adel(f_adel),
        .f_bd(f_bd), .d_ri(d_ri), .e_ov(e_ov), .e_adel(e_adel), .e_ades(e_ades),
        .m_is_eret(m_is_eret), .cp0_take(cp0_take), .cp0_epc(cp0_epc),
        .cp0_pc(cp0_pc), .cp0_bd(cp0_bd), .cp0_exc_code(cp0_exc_code),
        .cp0_exl_set(cp0_exl_set), .cp0_exl_clr(cp0_exl_clr), .flush(flush),
        .redir(redir), .npc(npc), .m_kill(m_kill), .in_handler(in_handler)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expect the record for the instruction being driven now to reach M after lat edges.
    task automatic push(input string tag, input logic [31:0] pc, input logic bd,
                        input logic exc, input logic [4:0] code, input int lat);
        expItem_t it;
        it.due = cyc + lat; it.tag = tag; it.pc = pc; it.bd = bd; it.exc = exc; it.code = code;
        sbq.push_back(it);
    endtask

    // Advance one edge, sample 1 time unit later and retire due scoreboard entries.
    task automatic tick();
        expItem_t it;
        @(posedge clk);
        cyc++;
        #1;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            it = sbq.pop_front();
            check({it.tag, "_due"}, cyc, it.due);
            check({it.tag, "_pc"}, cp0_pc, it.pc);
            check({it.tag, "_bd"}, cp0_bd, it.bd);
            check({it.tag, "_exl_set"}, cp0_exl_set, it.exc);
            check({it.tag, "_code"}, cp0_exc_code, it.code);
        end
    endtask

    initial begin
        reset = 1; stall = 0; f_pc = 32'h3000; f_adel = 0; f_bd = 0; d_ri = 0;
        e_ov = 0; e_adel = 0; e_ades = 0; m_is_eret = 0; cp0_take = 0; cp0_epc = 0;
        tick(); tick();

        // Reset state
        check("rst_pc", cp0_pc, 32'h3000);
        check("rst_exl_set", cp0_exl_set, 0);
        check("rst_flush", flush, 0);
        check("rst_redir", redir, 0);
        check("rst_npc", npc, 0);
        check("rst_m_kill", m_kill, 0);
        check("rst_in_handler", in_handler, 0);
        reset = 0;
        tick();

        // 1. Overflow reaches M, then CP0 takes it
        push("ov", 32'h3010, 0, 1, 5'd12, 3);
        f_pc = 32'h3010; tick();
        f_pc = 32'h3014; tick();
        e_ov = 1; tick();
        e_ov = 0; cp0_take = 1; #1;
        check("ov_flush", flush, 1);
        check("ov_redir", redir, 1);
        check("ov_npc", npc, 32'h4180);
        check("ov_m_kill", m_kill, 1);
        check("ov_exl_clr", cp0_exl_clr, 0);
        tick();
        cp0_take = 0;
        check("ov_in_handler", in_handler, 1);
        check("ov_bubble_pc", cp0_pc, 32'h4180);
        check("ov_bubble_exl", cp0_exl_set, 0);

        // 2. RI in a delay slot
        push("br", 32'h3020, 0, 0, 5'd0, 3);
        f_pc = 32'h3020; f_bd = 0; tick();
        push("ri_slot", 32'h3024, 1, 1, 5'd10, 3);
        f_pc = 32'h3024; f_bd = 1; tick();
        f_pc = 32'h3028; f_bd = 0; d_ri = 1; tick();
        d_ri = 0; tick();

        // 3. Stall bubble in M taken as interrupt
        push("stall_bubble", 32'h3040, 0, 0, 5'd0, 3);
        f_pc = 32'h3040; tick();
        stall = 1; f_pc = 32'h3044; tick(); tick();
        stall = 0; cp0_take = 1; #1;
        check("irq_npc", npc, 32'h4180);
        check("irq_redir", redir, 1);
        tick();
        cp0_take = 0;
        check("irq_in_handler", in_handler, 1);

        // 4. Fetch AdEL beats later RI on the same instruction
        push("adel_prio", 32'h3001, 0, 1, 5'd4, 3);
        f_pc = 32'h3001; f_adel = 1; tick();
        f_pc = 32'h3004; f_adel = 0; d_ri = 1; tick();
        d_ri = 0; tick();
        check("noraise_m_kill", m_kill, 0);
        check("noraise_flush", flush, 0);

        // 5. eret in HANDLER, with and without a simultaneous take
        check("eret_pre_handler", in_handler, 1);
        m_is_eret = 1; cp0_epc = 32'h3044; cp0_take = 1; #1;
        check("both_exl_clr", cp0_exl_clr, 0);
        check("both_npc", npc, 32'h4180);
        check("both_m_kill", m_kill, 1);
        cp0_take = 0; #1;
        check("eret_exl_clr", cp0_exl_clr, 1);
        check("eret_npc", npc, 32'h3044);
        check("eret_flush", flush, 1);
        check("eret_m_kill", m_kill, 0);
        tick();
        check("eret_in_handler", in_handler, 0);
        check("eret_bubble_pc", cp0_pc, 32'h3044);
        tick();
        m_is_eret = 0;
        check("eret_normal_stays", in_handler, 0);

        // 6. Reset while in HANDLER with an exception pending in E
        cp0_take = 1; tick();
        cp0_take = 0;
        f_pc = 32'h3050; f_adel = 1; tick();
        f_adel = 0; tick();
        check("rst6_pre_handler", in_handler, 1);
        reset = 1; cp0_take = 1; m_is_eret = 1; #1;
        check("rst6_flush_gated", flush, 0);
        check("rst6_redir_gated", redir, 0);
        tick();
        reset = 0; cp0_take = 0; m_is_eret = 0; #1;
        check("rst6_pc", cp0_pc, 32'h3000);
        check("rst6_exl_set", cp0_exl_set, 0);
        check("rst6_flush", flush, 0);
        check("rst6_in_handler", in_handler, 0);
        tick();
        check("rst6_pending_dropped", cp0_exl_set, 0);

        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
